i_mem_loadable: RTL and testbench
=================================

# i_mem_loadable

Parametrised, runtime-loadable instruction memory for the single-cycle RISC-V core. It replaces the fixed, asynchronously read program store with a synchronous-read RAM. On reset the RAM is swept to NOP. A byte-serial loader port (fed by the IO/UART path) writes a program while the core is stalled. The fetch port sits between the PC register and the decoder.

## Interface
- `ADDR_W`, default 8: word-address width; depth = 2**ADDR_W words.
- `DATA_W`, default 32: instruction width; must be a multiple of 8.
- `FILL`, default 32'h00000013: word written to every location during the clear sweep (addi x0,x0,0).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch request in this cycle.
- `fetch_addr`  in  ADDR_W  word address (PC[ADDR_W+1:2]).
- `fetch_data`  out  DATA_W  registered instruction word.
- `fetch_valid`  out  1  `fetch_data` holds the word for the previous cycle's request.
- `fetch_stall`  out  1  memory not serving fetches (CLEAR or LOAD).
- `load_start`  in  1  begin programming at word 0.
- `load_byte_valid`  in  1  `load_byte` is valid this cycle.
- `load_byte`  in  8  program byte, little-endian within each word.
- `load_done`  in  1  end programming.
- `load_count`  out  ADDR_W+1  complete words written by the current/last load.
- `load_err`  out  1  sticky flag: overflow or partial final word.

## Operation
- States: CLEAR, RUN, LOAD.
- Reset values: state CLEAR, clear pointer 0, `fetch_data` = FILL, `fetch_valid` 0, `fetch_stall` 1, `load_count` 0, `load_err` 0, byte index 0, word pointer 0.
- **CLEAR**
  - Each cycle writes FILL at the clear pointer, then increments it.
  - After writing address DEPTH-1, moves to RUN.
  - All loader inputs and `fetch_req` are ignored.
- **RUN**
  - `fetch_req` reads `mem[fetch_addr]` into `fetch_data` and sets `fetch_valid` 1.
  - With no request, `fetch_valid` is 0 and `fetch_data` holds its value.
  - `load_start` moves to LOAD and clears the word pointer, byte index, `load_count` and `load_err`. It has priority over a same-cycle `fetch_req`, which is dropped.
- **LOAD**
  - Each `load_byte_valid` places `load_byte` into byte lane `byte_idx` of an assembly register.
  - When the lane-(DATA_W/8−1) byte arrives, the full word is written at the word pointer, the pointer and `load_count` increment, and the byte index returns to 0.
  - Overflow: any byte arriving when `load_count` == DEPTH is dropped and sets `load_err`.
  - `load_done` returns to RUN.
    - A byte valid in the same cycle is accepted first.
    - If the byte index is nonzero after that, the partial word is discarded and `load_err` is set.
  - `load_start` in LOAD restarts: pointer, index, count and err are cleared, and any partial word is discarded.
  - Unwritten locations keep their previous contents; they are not re-cleared.
- `rst` asserted in any state, including mid-load, forces CLEAR. The next sweep wipes all contents.

## Timing
- Reset applied at edge E0. CLEAR writes address k on the edge E0+1+k. The state is RUN and `fetch_stall` is 0 after edge E0+DEPTH.
- Fetch latency is 1 cycle: a request sampled at edge N gives `fetch_data`/`fetch_valid` after edge N. There is no combinational path from `fetch_addr` to `fetch_data`.
- A write and a same-address read cannot coincide, because fetch is only served in RUN and writes happen only in CLEAR/LOAD.
- `fetch_stall` is combinational from state. It rises in the cycle after `load_start` is sampled and falls in the cycle after `load_done` is sampled.
- `load_count` updates on the edge that writes the word.
- Throughput: one byte per cycle maximum, no backpressure.

## Test plan
- **Reset sweep:** assert `rst` 1 cycle, then wait 256 cycles. Required: `fetch_stall` = 1 throughout; then fetch addr 0, 5 and 255 each return 32'h00000013 one cycle later with `fetch_valid` = 1.
- **Program load:** `load_start`, then bytes 93 02 00 00 83 22 10 02, then `load_done`. Required: `load_count` = 2, `load_err` = 0; fetch 0 → 32'h00000293, fetch 1 → 32'h02102283, fetch 2 → 32'h00000013.
- **Partial word:** `load_start`, 5 bytes, `load_done`. Required: `load_count` = 1, `load_err` = 1; word 1 still holds its previous content.
- **Overflow:** with ADDR_W = 2, load 20 bytes. Required: `load_count` = 4, `load_err` = 1, words 0–3 correct.
- **Fetch during load:** `fetch_req` = 1 in the same cycle as `load_start` and throughout LOAD. Required: `fetch_valid` = 0 and `fetch_stall` = 1 until the cycle after `load_done`.
- **Reset mid-load:** `rst` after 6 bytes. Required: `load_count` = 0, `load_err` = 0, and after DEPTH cycles every word = FILL.

Source files
------------

// File: rtl/i_mem_loadable.sv
// ============================================================================
// i_mem_loadable
// ----------------------------------------------------------------------------
// Runtime-loadable instruction memory for the single-cycle RISC-V core.
//
// The program store is a synchronous-read RAM with one write port and one
// registered read port. After reset the whole RAM is swept to FILL (a NOP)
// one word per cycle. Once the sweep is done the memory serves instruction
// fetches. A byte-serial loader, fed from the IO/UART path, can then write a
// new program while the core is held off by fetch_stall.
//
// Operating modes:
//   CLEAR : sweep FILL into every word, one word per cycle.
//   RUN   : serve fetches with one cycle of latency.
//   LOAD  : assemble little-endian bytes into words and write them from
//           word 0 upwards.
//
// Parameters:
//   ADDR_W : word-address width; the RAM holds 2**ADDR_W words.
//   DATA_W : instruction width in bits; must be a multiple of 8.
//   FILL   : word written to every location by the clear sweep.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous, active-high reset
//   fetch_req       in   fetch request this cycle
//   fetch_addr      in   word address (PC[ADDR_W+1:2])
//   fetch_data      out  registered instruction word
//   fetch_valid     out  fetch_data holds the word for last cycle's request
//   fetch_stall     out  memory is not serving fetches (CLEAR or LOAD)
//   load_start      in   begin (or restart) programming at word 0
//   load_byte_valid in   load_byte is valid this cycle
//   load_byte       in   program byte, little-endian within each word
//   load_done       in   end programming
//   load_count      out  complete words written by the current/last load
//   load_err        out  sticky: overflow or partial final word
// ============================================================================
module i_mem_loadable #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] FILL   = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              fetch_stall,
    input  logic              load_start,
    input  logic              load_byte_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;
    // A one-lane word still gets a 1-bit index so the register is never
    // zero-width; it simply stays at 0.
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_LANE  = IDX_W'(LANES - 1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] clr_ptr_q,    clr_ptr_d;
    logic [ADDR_W-1:0] word_ptr_q,   word_ptr_d;
    logic [IDX_W-1:0]  byte_idx_q,   byte_idx_d;
    logic [DATA_W-1:0] asm_q,        asm_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_err_q,   load_err_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write-port and read-port controls, decoded from the state machine.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              fetch_rd;

    // Assembly register with the incoming byte merged into its current lane.
    // When the last lane arrives this is the complete word to write.
    logic [DATA_W-1:0] asm_merged;

    always_comb begin
        asm_merged = asm_q;
        for (int l = 0; l < LANES; l++) begin
            if (byte_idx_q == IDX_W'(l)) begin
                asm_merged[l*8 +: 8] = load_byte;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        word_ptr_d    = word_ptr_q;
        byte_idx_d    = byte_idx_q;
        asm_d         = asm_q;
        load_count_d  = load_count_q;
        load_err_d    = load_err_q;
        fetch_valid_d = 1'b0;
        fetch_rd      = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = clr_ptr_q;
        mem_wdata     = FILL;

        case (state_q)
            ST_CLEAR: begin
                // Loader inputs and fetch requests are ignored during the sweep.
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = FILL;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // A load request wins over a same-cycle fetch, which is dropped.
                if (load_start) begin
                    state_d      = ST_LOAD;
                    word_ptr_d   = '0;
                    byte_idx_d   = '0;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end else if (fetch_req) begin
                    fetch_rd      = 1'b1;
                    fetch_valid_d = 1'b1;
                end
            end

            ST_LOAD: begin
                if (load_start) begin
                    // Restart: any partially assembled word is discarded.
                    word_ptr_d   = '0;
                    byte_idx_d   = '0;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end else begin
                    if (load_byte_valid) begin
                        if (load_count_q == FULL_COUNT) begin
                            // Memory already full: drop the byte.
                            load_err_d = 1'b1;
                        end else if (byte_idx_q == LAST_LANE) begin
                            mem_we       = 1'b1;
                            mem_waddr    = word_ptr_q;
                            mem_wdata    = asm_merged;
                            word_ptr_d   = word_ptr_q + ADDR_W'(1);
                            load_count_d = load_count_q + (ADDR_W + 1)'(1);
                            byte_idx_d   = '0;
                        end else begin
                            asm_d      = asm_merged;
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end

                    // A byte in the same cycle as load_done was taken above,
                    // so byte_idx_d already reflects it.
                    if (load_done) begin
                        state_d = ST_RUN;
                        if (byte_idx_d != '0) begin
                            load_err_d = 1'b1;
                        end
                        byte_idx_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            word_ptr_q    <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            load_count_q  <= '0;
            load_err_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= FILL;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            word_ptr_q    <= word_ptr_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            load_count_q  <= load_count_d;
            load_err_q    <= load_err_d;
            fetch_valid_q <= fetch_valid_d;
            // Registered read: fetch_data holds when there is no request.
            if (fetch_rd) begin
                fetch_data_q <= mem_q[fetch_addr];
            end
        end
    end

    // NOTE: the RAM array has no reset; it is initialised by the CLEAR sweep,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_stall = (state_q != ST_RUN);
    assign load_count  = load_count_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_i_mem_loadable.sv
// ============================================================================
// tb_i_mem_loadable
// ----------------------------------------------------------------------------
// Self-checking bench for i_mem_loadable. A 256-word instance covers sweep,
// fetch, program load, partial words, restart and reset mid-load; a 4-word
// instance covers overflow. Expected memory contents come from a word-array
// model updated from the byte stream of each load session.
// ============================================================================
module tb_i_mem_loadable;

    localparam int          AW     = 8;
    localparam int          DEPTH  = 256;
    localparam int          SAW    = 2;
    localparam logic [31:0] FILL   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          rst, fetch_req, load_start, load_byte_valid, load_done;
    logic [AW-1:0] fetch_addr;
    logic [7:0]    load_byte;
    logic [31:0]   fetch_data;
    logic          fetch_valid, fetch_stall, load_err;
    logic [AW:0]   load_count;

    // Small instance signals
    logic           s_rst, s_fetch_req, s_load_start, s_load_byte_valid, s_load_done;
    logic [SAW-1:0] s_fetch_addr;
    logic [7:0]     s_load_byte;
    logic [31:0]    s_fetch_data;
    logic           s_fetch_valid, s_fetch_stall, s_load_err;
    logic [SAW:0]   s_load_count;

    i_mem_loadable #(.ADDR_W(AW), .DATA_W(32), .FILL(FILL)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_data     (fetch_data),
        .fetch_valid    (fetch_valid),
        .fetch_stall    (fetch_stall),
        .load_start     (load_start),
        .load_byte_valid(load_byte_valid),
        .load_byte      (load_byte),
        .load_done      (load_done),
        .load_count     (load_count),
        .load_err       (load_err)
    );

    i_mem_loadable #(.ADDR_W(SAW), .DATA_W(32), .FILL(FILL)) u_small (
        .clk            (clk),
        .rst            (s_rst),
        .fetch_req      (s_fetch_req),
        .fetch_addr     (s_fetch_addr),
        .fetch_data     (s_fetch_data),
        .fetch_valid    (s_fetch_valid),
        .fetch_stall    (s_fetch_stall),
        .load_start     (s_load_start),
        .load_byte_valid(s_load_byte_valid),
        .load_byte      (s_load_byte),
        .load_done      (s_load_done),
        .load_count     (s_load_count),
        .load_err       (s_load_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: memory image plus the outcome of the last session.
    logic [31:0] model_mem [DEPTH];
    int          model_count;
    logic        model_err;
    logic [7:0]  stim_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {stim_q[4*w+3], stim_q[4*w+2], stim_q[4*w+1], stim_q[4*w]};
    endfunction

    // Apply a load session of stim_q to the model: complete words land from
    // word 0 upward (capped at the depth), and the error flag reflects
    // overflow or a trailing partial word.
    task automatic model_apply(input int depth);
        int n;
        int full;
        n    = stim_q.size();
        full = n / 4;
        if (full > depth) full = depth;
        for (int w = 0; w < full; w++) model_mem[w] = word_of(w);
        model_count = full;
        model_err   = (n > 4 * depth) || (n % 4 != 0);
    endtask

    // One-cycle reset, then the full clear sweep with random junk on every
    // input (all of which must be ignored).
    task automatic sweep_main();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_stall", 32'(fetch_stall), 32'd1);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_data",  fetch_data,       FILL);
        check("rst_count", 32'(load_count),  32'd0);
        check("rst_err",   32'(load_err),    32'd0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            fetch_req       = 1'($urandom);
            fetch_addr      = AW'($urandom);
            load_start      = 1'($urandom);
            load_byte_valid = 1'($urandom);
            load_byte       = 8'($urandom);
            load_done       = 1'($urandom);
            tick();
            check("clear_stall", 32'(fetch_stall), 32'd1);
            check("clear_valid", 32'(fetch_valid), 32'd0);
        end
        fetch_req = 1'b0; load_start = 1'b0; load_byte_valid = 1'b0; load_done = 1'b0;
        tick();
        check("sweep_end_stall", 32'(fetch_stall), 32'd0);
        check("sweep_end_count", 32'(load_count),  32'd0);
        check("sweep_end_err",   32'(load_err),    32'd0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = FILL;
    endtask

    task automatic fetch_chk(input int a);
        fetch_req  = 1'b1;
        fetch_addr = AW'(a);
        tick();
        fetch_req = 1'b0;
        check("fetch_valid", 32'(fetch_valid), 32'd1);
        check("fetch_data",  fetch_data,       model_mem[a]);
    endtask

    // Send stim_q as one load session. finish=0 leaves the loader in LOAD
    // (for restart / reset tests). done_with_last raises load_done together
    // with the final byte. fetch_on holds fetch_req high throughout.
    task automatic load_session(input bit finish, input bit done_with_last, input bit fetch_on);
        bit done_sent;
        done_sent  = 1'b0;
        fetch_req  = fetch_on;
        fetch_addr = AW'($urandom);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ld_start_stall", 32'(fetch_stall), 32'd1);
        check("ld_start_valid", 32'(fetch_valid), 32'd0);
        for (int i = 0; i < stim_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_byte = 8'($urandom);
                tick();
                check("ld_idle_stall", 32'(fetch_stall), 32'd1);
            end
            load_byte_valid = 1'b1;
            load_byte       = stim_q[i];
            if (finish && done_with_last && i == stim_q.size() - 1) begin
                load_done = 1'b1;
                done_sent = 1'b1;
            end
            fetch_addr = AW'($urandom);
            tick();
            load_byte_valid = 1'b0;
            load_byte       = 8'($urandom);
            check("ld_valid", 32'(fetch_valid), 32'd0);
            check("ld_count", 32'(load_count),  32'((i + 1) / 4));
            if (!done_sent) check("ld_stall", 32'(fetch_stall), 32'd1);
        end
        if (finish && !done_sent) begin
            load_done = 1'b1;
            tick();
        end
        load_done = 1'b0;
        fetch_req = 1'b0;
        model_apply(DEPTH);
        if (finish) begin
            check("done_stall", 32'(fetch_stall), 32'd0);
            check("done_valid", 32'(fetch_valid), 32'd0);
            check("done_count", 32'(load_count),  32'(model_count));
            check("done_err",   32'(load_err),    32'(model_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
        load_byte_valid = 1'b0; load_byte = '0; load_done = 1'b0;
        s_rst = 1'b1; s_fetch_req = 1'b0; s_fetch_addr = '0; s_load_start = 1'b0;
        s_load_byte_valid = 1'b0; s_load_byte = '0; s_load_done = 1'b0;
        tick();
        s_rst = 1'b0;

        // Reset sweep, then fetches at the edges of the address range.
        sweep_main();
        fetch_chk(0);
        fetch_chk(5);
        fetch_chk(255);
        check("fill_literal", fetch_data, 32'h0000_0013);
        tick();
        check("idle_valid", 32'(fetch_valid), 32'd0);
        check("idle_hold",  fetch_data,       32'h0000_0013);

        // Program load with fetch requested throughout.
        stim_q = '{8'h93, 8'h02, 8'h00, 8'h00, 8'h83, 8'h22, 8'h10, 8'h02};
        load_session(1'b1, 1'b0, 1'b1);
        check("prog_count", 32'(load_count), 32'd2);
        check("prog_err",   32'(load_err),   32'd0);
        fetch_chk(0);
        check("prog_w0", fetch_data, 32'h0000_0293);
        fetch_chk(1);
        check("prog_w1", fetch_data, 32'h0210_2283);
        fetch_chk(2);
        check("prog_w2", fetch_data, 32'h0000_0013);

        // Partial final word: word 1 keeps its earlier content.
        stim_q = {};
        for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom));
        load_session(1'b1, 1'($urandom), 1'b1);
        check("part_count", 32'(load_count), 32'd1);
        check("part_err",   32'(load_err),   32'd1);
        fetch_chk(0);
        fetch_chk(1);
        check("part_w1_kept", fetch_data, 32'h0210_2283);

        // Restart mid-load: the first session's full word stays written
        // until the second session overwrites it.
        stim_q = {};
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        load_session(1'b0, 1'b0, 1'b1);
        stim_q = {};
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
        load_session(1'b1, 1'b1, 1'b0);
        for (int a = 0; a < 4; a++) fetch_chk(a);

        // Random sessions, including empty ones.
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(0, 28);
            stim_q = {};
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            load_session(1'b1, 1'($urandom), 1'($urandom));
            for (int j = 0; j < 6; j++) fetch_chk($urandom_range(0, 9));
            fetch_chk($urandom_range(0, DEPTH - 1));
        end

        // Reset mid-load wipes everything.
        stim_q = {};
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        load_session(1'b0, 1'b0, 1'b0);
        sweep_main();
        for (int a = 0; a < DEPTH; a++) fetch_chk(a);

        // Overflow on the 4-word instance: 20 bytes, only 16 fit.
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        check("s_start_stall", 32'(s_fetch_stall), 32'd1);
        stim_q = {};
        for (int i = 0; i < 20; i++) begin
            stim_q.push_back(8'($urandom));
            s_load_byte_valid = 1'b1;
            s_load_byte       = stim_q[i];
            tick();
            s_load_byte_valid = 1'b0;
            check("s_count", 32'(s_load_count), 32'((i + 1) / 4 > 4 ? 4 : (i + 1) / 4));
            check("s_err",   32'(s_load_err),   32'((i + 1) > 16));
        end
        s_load_done = 1'b1;
        tick();
        s_load_done = 1'b0;
        check("s_done_stall", 32'(s_fetch_stall), 32'd0);
        check("s_ovf_count",  32'(s_load_count),  32'd4);
        check("s_ovf_err",    32'(s_load_err),    32'd1);
        for (int a = 0; a < 4; a++) begin
            s_fetch_req  = 1'b1;
            s_fetch_addr = SAW'(a);
            tick();
            s_fetch_req = 1'b0;
            check("s_fetch_valid", 32'(s_fetch_valid), 32'd1);
            check("s_fetch_data",  s_fetch_data,       word_of(a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
